// File: rtl/mem_wb_if.sv
`default_nettype none
// mem_wb_if: EXE/MEM operands into the MEM stage and MEM/WB results out of it.
// The fault signal exists only when MEM_MISALIGN_TRAP_EN is defined.
interface mem_wb_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_rd;
   logic [1:0]  data_size;
   logic        load_instr;
   logic        store_instr;
   logic        rf_en;
   logic [31:0] mem_fwd_data;
   logic        stall;
   logic [31:0] wb_data;
   logic [3:0]  wb_rd;
   logic        wb_rf_en;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        fault;

   modport master (
      output mem_addr, mem_wdata, mem_rd, data_size, load_instr, store_instr, rf_en,
      input  mem_fwd_data, stall, wb_data, wb_rd, wb_rf_en, fault
   );
   modport slave (
      input  mem_addr, mem_wdata, mem_rd, data_size, load_instr, store_instr, rf_en,
      output mem_fwd_data, stall, wb_data, wb_rd, wb_rf_en, fault
   );
`else
   modport master (
      output mem_addr, mem_wdata, mem_rd, data_size, load_instr, store_instr, rf_en,
      input  mem_fwd_data, stall, wb_data, wb_rd, wb_rf_en
   );
   modport slave (
      input  mem_addr, mem_wdata, mem_rd, data_size, load_instr, store_instr, rf_en,
      output mem_fwd_data, stall, wb_data, wb_rd, wb_rf_en
   );
`endif
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_wb_stage: MEM stage (big-endian byte RAM) plus MEM/WB pipeline register.
// Optional: MEM_MISALIGN_TRAP_EN adds a registered fault output.  Rev 1.0
// ---------------------------------------------------------------------------
module mem_wb_stage #(
   parameter int DEPTH   = 256,
   parameter int MEM_LAT = 1
) (
   input wire        clk,
   input wire        reset,
   mem_wb_if.slave   mem_if
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = 4;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      ram_q [DEPTH];

   logic [31:0]     wb_data_q, wb_data_d;
   logic [3:0]      wb_rd_q, wb_rd_d;
   logic            wb_rf_en_q, wb_rf_en_d;

   logic            w_load, w_store, w_mem;
   logic            w_stall_raw, w_complete, w_trap, w_wr_en;
   logic [AW-1:0]   w_idx, w_a0, w_a1, w_a2, w_a3;
   logic [7:0]      w_b0, w_b1, w_b2, w_b3;
   logic [31:0]     w_rdata;

   // Both flags high is treated as a load that never writes.
   assign w_load  = mem_if.load_instr;
   assign w_store = mem_if.store_instr & ~mem_if.load_instr;
   assign w_mem   = mem_if.load_instr | mem_if.store_instr;

   assign w_idx = mem_if.mem_addr[AW-1:0];

   always_comb begin
      w_a0 = w_idx;
      case (mem_if.data_size)
         2'b00:   w_a0 = w_idx;
         2'b01:   w_a0 = {w_idx[AW-1:1], 1'b0};
         default: w_a0 = {w_idx[AW-1:2], 2'b00};
      endcase
   end

   assign w_a1 = w_a0 + AW'(1);
   assign w_a2 = w_a0 + AW'(2);
   assign w_a3 = w_a0 + AW'(3);

   assign w_b0 = ram_q[w_a0];
   assign w_b1 = ram_q[w_a1];
   assign w_b2 = ram_q[w_a2];
   assign w_b3 = ram_q[w_a3];

   always_comb begin
      w_rdata = {w_b0, w_b1, w_b2, w_b3};
      case (mem_if.data_size)
         2'b00:   w_rdata = {24'b0, w_b0};
         2'b01:   w_rdata = {16'b0, w_b0, w_b1};
         default: w_rdata = {w_b0, w_b1, w_b2, w_b3};
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic w_misalign;
   logic fault_q, fault_d;

   always_comb begin
      w_misalign = 1'b0;
      case (mem_if.data_size)
         2'b00:   w_misalign = 1'b0;
         2'b01:   w_misalign = mem_if.mem_addr[0];
         default: w_misalign = (mem_if.mem_addr[1:0] != 2'b00);
      endcase
   end

   assign w_trap  = w_mem & w_misalign;
   assign fault_d = w_complete & w_trap;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end

   assign mem_if.fault = fault_q;
`else
   assign w_trap = 1'b0;
`endif

   // Latency FSM: WAIT counts the remaining stall cycles down to the completion edge.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      w_stall_raw = 1'b0;
      if (MEM_LAT > 1) begin
         case (state_q)
            S_IDLE: begin
               if (w_mem) begin
                  w_stall_raw = 1'b1;
                  state_d     = S_WAIT;
                  cnt_d       = CW'(MEM_LAT - 2);
               end
            end
            S_WAIT: begin
               if (cnt_q != '0) begin
                  w_stall_raw = 1'b1;
                  cnt_d       = cnt_q - CW'(1);
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign w_complete = w_mem & ~w_stall_raw;

   always_comb begin
      wb_data_d  = wb_data_q;
      wb_rd_d    = wb_rd_q;
      wb_rf_en_d = wb_rf_en_q;
      if (w_stall_raw) begin
         wb_rf_en_d = 1'b0;
      end else if (w_load) begin
         wb_data_d  = w_rdata;
         wb_rd_d    = mem_if.mem_rd;
         wb_rf_en_d = mem_if.rf_en & ~w_trap;
      end else if (w_store) begin
         wb_rd_d    = mem_if.mem_rd;
         wb_rf_en_d = 1'b0;
      end else begin
         wb_data_d  = mem_if.mem_addr;
         wb_rd_d    = mem_if.mem_rd;
         wb_rf_en_d = mem_if.rf_en;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
         wb_rf_en_q <= 1'b0;
      end else begin
         wb_data_q  <= wb_data_d;
         wb_rd_q    <= wb_rd_d;
         wb_rf_en_q <= wb_rf_en_d;
      end
   end

   // RAM has no reset; gating with reset keeps an aborted store from landing.
   assign w_wr_en = w_complete & w_store & ~w_trap & ~reset;

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         case (mem_if.data_size)
            2'b00: begin
               ram_q[w_a0] <= mem_if.mem_wdata[7:0];
            end
            2'b01: begin
               ram_q[w_a0] <= mem_if.mem_wdata[15:8];
               ram_q[w_a1] <= mem_if.mem_wdata[7:0];
            end
            default: begin
               ram_q[w_a0] <= mem_if.mem_wdata[31:24];
               ram_q[w_a1] <= mem_if.mem_wdata[23:16];
               ram_q[w_a2] <= mem_if.mem_wdata[15:8];
               ram_q[w_a3] <= mem_if.mem_wdata[7:0];
            end
         endcase
      end
   end

   assign mem_if.mem_fwd_data = w_load ? w_rdata : mem_if.mem_addr;
   assign mem_if.stall        = w_stall_raw & ~reset;
   assign mem_if.wb_data      = wb_data_q;
   assign mem_if.wb_rd        = wb_rd_q;
   assign mem_if.wb_rf_en     = wb_rf_en_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// tb_mem_wb_stage: directed checks of mem_wb_stage at MEM_LAT 1, 3 and 4.
module tb_mem_wb_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1, rst3, rst4;
   int   checks = 0;
   int   errors = 0;

   mem_wb_if if1 ();
   mem_wb_if if3 ();
   mem_wb_if if4 ();

   mem_wb_stage #(.DEPTH(256), .MEM_LAT(1)) u_lat1 (.clk(clk), .reset(rst1), .mem_if(if1));
   mem_wb_stage #(.DEPTH(256), .MEM_LAT(3)) u_lat3 (.clk(clk), .reset(rst3), .mem_if(if3));
   mem_wb_stage #(.DEPTH(256), .MEM_LAT(4)) u_lat4 (.clk(clk), .reset(rst4), .mem_if(if4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic op(input int which, input logic ld, input logic st, input logic [1:0] sz,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] rd,
                     input logic rf);
      case (which)
         1: begin
            if1.load_instr = ld; if1.store_instr = st; if1.data_size = sz;
            if1.mem_addr = addr; if1.mem_wdata = wd; if1.mem_rd = rd; if1.rf_en = rf;
         end
         3: begin
            if3.load_instr = ld; if3.store_instr = st; if3.data_size = sz;
            if3.mem_addr = addr; if3.mem_wdata = wd; if3.mem_rd = rd; if3.rf_en = rf;
         end
         default: begin
            if4.load_instr = ld; if4.store_instr = st; if4.data_size = sz;
            if4.mem_addr = addr; if4.mem_wdata = wd; if4.mem_rd = rd; if4.rf_en = rf;
         end
      endcase
   endtask

   initial begin
      rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
      op(1, 0, 0, 2'b10, 32'h0, 32'h0, 4'h0, 1'b0);
      op(3, 0, 0, 2'b10, 32'h0, 32'h0, 4'h0, 1'b0);
      op(4, 0, 0, 2'b10, 32'h0, 32'h0, 4'h0, 1'b0);
      #1;
      chk("rst_wb_data", if1.wb_data, 32'h0);
      chk("rst_wb_rd", {28'h0, if1.wb_rd}, 32'h0);
      chk("rst_wb_rf_en", {31'h0, if1.wb_rf_en}, 32'h0);
      chk("rst_stall4", {31'h0, if4.stall}, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("rst_fault", {31'h0, if1.fault}, 32'h0);
`endif
      @(negedge clk);
      rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;

      // ---- MEM_LAT=1 ----
      @(negedge clk);
      op(1, 0, 1, 2'b10, 32'h10, 32'h11223344, 4'h0, 1'b0);
      #1 chk("l1_st_stall", {31'h0, if1.stall}, 32'h0);
      @(posedge clk); #1 chk("l1_st_rfen", {31'h0, if1.wb_rf_en}, 32'h0);

      @(negedge clk);
      op(1, 1, 0, 2'b00, 32'h11, 32'h0, 4'h3, 1'b1);
      #1 chk("l1_ldb_fwd", if1.mem_fwd_data, 32'h00000022);
      @(posedge clk); #1;
      chk("l1_ldb_data", if1.wb_data, 32'h00000022);
      chk("l1_ldb_rd", {28'h0, if1.wb_rd}, 32'h3);
      chk("l1_ldb_rfen", {31'h0, if1.wb_rf_en}, 32'h1);

      @(negedge clk);
      op(1, 1, 0, 2'b01, 32'h12, 32'h0, 4'h4, 1'b1);
      #1 chk("l1_ldh_stall", {31'h0, if1.stall}, 32'h0);
      @(posedge clk); #1 chk("l1_ldh_data", if1.wb_data, 32'h00003344);

      // misaligned halfword load at 0x11
      @(negedge clk);
      op(1, 1, 0, 2'b01, 32'h11, 32'h0, 4'h4, 1'b1);
      @(posedge clk); #1;
`ifdef MEM_MISALIGN_TRAP_EN
      chk("l1_mis_rfen", {31'h0, if1.wb_rf_en}, 32'h0);
      chk("l1_mis_fault", {31'h0, if1.fault}, 32'h1);
`else
      chk("l1_mis_data", if1.wb_data, 32'h00001122);
`endif

      @(negedge clk);
      op(1, 0, 0, 2'b10, 32'hDEADBEEF, 32'h0, 4'h5, 1'b1);
      #1 chk("l1_alu_fwd", if1.mem_fwd_data, 32'hDEADBEEF);
      @(posedge clk); #1;
      chk("l1_alu_data", if1.wb_data, 32'hDEADBEEF);
      chk("l1_alu_rd", {28'h0, if1.wb_rd}, 32'h5);
      chk("l1_alu_rfen", {31'h0, if1.wb_rf_en}, 32'h1);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("l1_fault_clr", {31'h0, if1.fault}, 32'h0);
`endif

      // address wrap
      @(negedge clk);
      op(1, 0, 1, 2'b00, 32'h1FF, 32'h123456AB, 4'h0, 1'b0);
      @(negedge clk);
      op(1, 1, 0, 2'b00, 32'hFF, 32'h0, 4'h6, 1'b1);
      @(posedge clk); #1 chk("l1_wrap_data", if1.wb_data, 32'h000000AB);

      // misaligned word store at 0x13
      @(negedge clk);
      op(1, 0, 1, 2'b10, 32'h13, 32'h55667788, 4'h0, 1'b1);
      @(posedge clk); #1 chk("l1_mst_rfen", {31'h0, if1.wb_rf_en}, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("l1_mst_fault", {31'h0, if1.fault}, 32'h1);
`endif
      @(negedge clk);
      op(1, 1, 0, 2'b10, 32'h10, 32'h0, 4'h8, 1'b1);
      @(posedge clk); #1;
`ifdef MEM_MISALIGN_TRAP_EN
      chk("l1_mst_fault_end", {31'h0, if1.fault}, 32'h0);
      chk("l1_mst_keep", if1.wb_data, 32'h11223344);
`else
      chk("l1_mst_wr", if1.wb_data, 32'h55667788);
`endif
      @(negedge clk);
      op(1, 0, 0, 2'b10, 32'h0, 32'h0, 4'h0, 1'b0);

      // ---- MEM_LAT=3 ----
      op(3, 0, 1, 2'b10, 32'h10, 32'h11223344, 4'h0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      op(3, 0, 0, 2'b10, 32'hCAFE0000, 32'h0, 4'h2, 1'b1);
      @(posedge clk); #1 chk("l3_alu_rfen", {31'h0, if3.wb_rf_en}, 32'h1);
      @(negedge clk);
      op(3, 1, 0, 2'b10, 32'h10, 32'h0, 4'h7, 1'b1);
      #1 chk("l3_stall_c0", {31'h0, if3.stall}, 32'h1);
      @(posedge clk); #1;
      chk("l3_bub1_rfen", {31'h0, if3.wb_rf_en}, 32'h0);
      chk("l3_bub1_hold", if3.wb_data, 32'hCAFE0000);
      chk("l3_stall_c1", {31'h0, if3.stall}, 32'h1);
      @(posedge clk); #1;
      chk("l3_bub2_rfen", {31'h0, if3.wb_rf_en}, 32'h0);
      chk("l3_stall_c2", {31'h0, if3.stall}, 32'h0);
      chk("l3_fwd", if3.mem_fwd_data, 32'h11223344);
      @(posedge clk); #1;
      chk("l3_ld_data", if3.wb_data, 32'h11223344);
      chk("l3_ld_rd", {28'h0, if3.wb_rd}, 32'h7);
      chk("l3_ld_rfen", {31'h0, if3.wb_rf_en}, 32'h1);
      @(negedge clk);
      op(3, 0, 0, 2'b10, 32'h0, 32'h0, 4'h0, 1'b0);

      // ---- MEM_LAT=4, reset aborts a store ----
      op(4, 0, 1, 2'b10, 32'h20, 32'hA1B2C3D4, 4'h0, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      op(4, 0, 0, 2'b10, 32'h1234, 32'h0, 4'h9, 1'b1);
      @(posedge clk); #1 chk("l4_alu_data", if4.wb_data, 32'h00001234);
      @(negedge clk);
      op(4, 0, 1, 2'b10, 32'h20, 32'hCAFEF00D, 4'h0, 1'b0);
      @(posedge clk);
      @(posedge clk); #1 chk("l4_wait2_stall", {31'h0, if4.stall}, 32'h1);
      #1 rst4 = 1'b1;
      #1;
      chk("l4_rst_data", if4.wb_data, 32'h0);
      chk("l4_rst_rd", {28'h0, if4.wb_rd}, 32'h0);
      chk("l4_rst_rfen", {31'h0, if4.wb_rf_en}, 32'h0);
      chk("l4_rst_stall", {31'h0, if4.stall}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst4 = 1'b0;
      op(4, 1, 0, 2'b10, 32'h20, 32'h0, 4'hA, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk("l4_old_data", if4.wb_data, 32'hA1B2C3D4);
      chk("l4_old_rfen", {31'h0, if4.wb_rf_en}, 32'h1);
      @(negedge clk);
      op(4, 0, 0, 2'b10, 32'h0, 32'h0, 4'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
